// File: rtl/uart_ctrl_pkg.sv
// Shared UART control types and constants: arbiter state encoding, data width,
// default gap/stall settings used by the transmitter, arbiter and top.
package uart_ctrl_pkg;

   localparam int unsigned UART_DATA_W     = 8;
   localparam int unsigned DEF_GAP_CYCLES  = 16;
   localparam int unsigned DEF_STALL_LIMIT = 1024;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      GAP
   } arb_state_e;

   // Bits needed to count 0..max_val, never less than one bit.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant,
// wrapping cyclically. Produces a one-hot winner and an any-valid flag.
module rr_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] winner,
   output logic               any_valid
);

   int unsigned pos;
   logic        found;

   // Scan from last_grant+1 around to last_grant itself; lowest offset wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      pos    = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         pos = (32'(last_grant) + k) % NUM_REQ;
         if (!found && valid[IDX_W'(pos)]) begin
            winner[IDX_W'(pos)] = 1'b1;
            found               = 1'b1;
         end
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters, granting
// whole messages round-robin with an idle gap between messages and stall abort.
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           tx_start,
   output logic [UART_DATA_W-1:0]         tx_data,
   input  logic                           tx_done,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           busy,
   output logic                           abort
);

   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STALL_W = cnt_w(STALL_LIMIT);
   localparam int unsigned GAP_W   = cnt_w(GAP_CYCLES);

   arb_state_e             state, state_n;
   logic [NUM_REQ-1:0]     grant_n;
   logic [IDX_W-1:0]       last_grant, last_grant_n;
   logic [UART_DATA_W-1:0] tx_data_n;
   logic                   tx_start_n;
   logic                   abort_n;
   logic                   last_q, last_q_n;
   logic [STALL_W-1:0]     stall_cnt, stall_cnt_n;
   logic [GAP_W-1:0]       gap_cnt, gap_cnt_n;

   logic [NUM_REQ-1:0]     winner;
   logic                   any_valid;
   logic [IDX_W-1:0]       winner_idx;
   logic [UART_DATA_W-1:0] sel_data;
   logic                   sel_last;
   logic                   handshake;
   logic                   done_ok;
   logic                   stall_hit;
   logic                   gap_end;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .valid      (req_valid),
      .last_grant (last_grant),
      .winner     (winner),
      .any_valid  (any_valid)
   );

   // Encode the arbiter winner and select the granted requester's byte.
   always_comb begin
      winner_idx = '0;
      sel_data   = '0;
      sel_last   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            winner_idx = IDX_W'(i);
         end
         if (grant[i]) begin
            sel_data = req_data[UART_DATA_W*i +: UART_DATA_W];
            sel_last = req_last[i];
         end
      end
   end

   assign req_ready = (state == SEND) ? (req_valid & grant) : '0;
   assign handshake = |req_ready;
   // A done coinciding with our own start pulse belongs to an earlier transfer.
   assign done_ok   = (state == WAIT) && tx_done && !tx_start;
   assign stall_hit = (32'(stall_cnt) + 32'd1) >= STALL_LIMIT;
   assign gap_end   = (32'(gap_cnt) + 32'd1) >= GAP_CYCLES;
   assign busy      = (state != IDLE);

   always_comb begin
      state_n      = state;
      grant_n      = grant;
      last_grant_n = last_grant;
      tx_data_n    = tx_data;
      tx_start_n   = 1'b0;
      abort_n      = 1'b0;
      last_q_n     = last_q;
      stall_cnt_n  = stall_cnt;
      gap_cnt_n    = gap_cnt;
      unique case (state)
         IDLE: begin
            if (any_valid) begin
               grant_n      = winner;
               last_grant_n = winner_idx;
               stall_cnt_n  = '0;
               state_n      = SEND;
            end
         end
         SEND: begin
            if (handshake) begin
               tx_data_n   = sel_data;
               last_q_n    = sel_last;
               tx_start_n  = 1'b1;
               stall_cnt_n = '0;
               state_n     = WAIT;
            end else if (stall_hit) begin
               abort_n     = 1'b1;
               grant_n     = '0;
               stall_cnt_n = '0;
               state_n     = IDLE;
            end else if (stall_cnt != STALL_W'(STALL_LIMIT)) begin
               stall_cnt_n = stall_cnt + 1'b1;
            end
         end
         WAIT: begin
            if (done_ok) begin
               if (!last_q) begin
                  state_n = SEND;
               end else begin
                  grant_n   = '0;
                  gap_cnt_n = '0;
                  state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
               end
            end
         end
         GAP: begin
            if (gap_end) begin
               gap_cnt_n = '0;
               state_n   = IDLE;
            end else begin
               gap_cnt_n = gap_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
         tx_data    <= '0;
         tx_start   <= 1'b0;
         abort      <= 1'b0;
         last_q     <= 1'b0;
         stall_cnt  <= '0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         last_grant <= last_grant_n;
         tx_data    <= tx_data_n;
         tx_start   <= tx_start_n;
         abort      <= abort_n;
         last_q     <= last_q_n;
         stall_cnt  <= stall_cnt_n;
         gap_cnt    <= gap_cnt_n;
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single UART transmitter between `NUM_REQ` byte-stream requesters.
- Grants a requester for a whole message, delimited by `last`, then moves to the next requester in round-robin order.
- Sequences each byte into the transmitter with a start/done handshake and inserts a programmable idle gap between messages.
- Aborts a message if the granted requester stalls too long.
- Sits between message sources (text formatters, command responders) and the UART transmitter in `top`.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8).
- `GAP_CYCLES`, 16, idle clocks between messages; 0 = no gap.
- `STALL_LIMIT`, 1024, max clocks without `req_valid` from the granted requester mid-message before abort.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NUM_REQ: per-requester byte available.
- `req_data` in 8*NUM_REQ: byte for requester i in bits [8i+7:8i].
- `req_last` in NUM_REQ: byte is the final one of its message.
- `req_ready` out NUM_REQ: byte accepted this cycle.
- `tx_start` out 1: one-clock pulse launching the transmitter.
- `tx_data` out 8: byte to transmit; held stable from `tx_start` until `tx_done`.
- `tx_done` in 1: one-clock pulse from the transmitter after the stop bit.
- `grant` out NUM_REQ: one-hot owner; 0 when idle.
- `busy` out 1: state != IDLE.
- `abort` out 1: one-clock pulse when a message is abandoned on stall.

## Operation
- States:
  - IDLE: no grant.
  - SEND: waiting for a byte from the granted requester.
  - WAIT: byte in flight.
  - GAP: inter-message spacing.
- IDLE: if any `req_valid`, pick the first valid requester after `last_grant`, cyclically. Set `grant`, `last_grant` <= winner, go to SEND.
- SEND:
  - `req_ready[g] = req_valid[g]` (combinational); all other `req_ready` bits 0.
  - On handshake: `tx_data` <= byte, `last_q` <= `req_last[g]`, `tx_start` <= 1 for the next clock, stall counter cleared, go to WAIT.
  - With no valid: stall counter increments. At `STALL_LIMIT`, pulse `abort`, clear `grant`, go to IDLE; no `tx_start` is issued.
- WAIT:
  - `tx_done` is ignored in the cycle `tx_start` is high and in every state other than WAIT.
  - On accepted `tx_done` with `last_q=0`: go to SEND, grant held.
  - On accepted `tx_done` with `last_q=1`: clear `grant` and go to GAP, or to IDLE if `GAP_CYCLES=0`.
- GAP: count `GAP_CYCLES` clocks, then go to IDLE. Requests are not arbitrated during GAP.
- Non-granted requesters never see `req_ready`. Their `req_valid` may stay high indefinitely.
- Stall counter width: clog2(`STALL_LIMIT`+1); saturates, never wraps. Gap counter width: clog2(`GAP_CYCLES`+1).
- Single-byte message (`last` on first byte) is legal: one `tx_start`, then GAP.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `busy`=0, `abort`=0, `last_grant`=NUM_REQ-1 (requester 0 wins first), counters 0, state IDLE.
- Reset mid-message: everything returns to reset values on the next edge. A transmitter already running is allowed to finish; its `tx_done` is ignored.
- Latency:
  - Valid in IDLE at cycle n: `grant` at n+1, `req_ready` at n+1, `tx_start` at n+2.
  - `tx_done` at cycle m (not last byte): SEND at m+1, next `tx_start` at m+2 at the earliest.
- Simultaneous requests: exactly one grant. Rotation happens only at message boundaries, never mid-message.

## Structure
- Shared package `uart_ctrl_pkg`:
  - state enum {IDLE, SEND, WAIT, GAP}
  - `UART_DATA_W`=8
  - default `GAP_CYCLES` and `STALL_LIMIT` constants, shared with the transmitter and `top`.
- One sub-module, `rr_arbiter`:
  - combinational round-robin pick over `NUM_REQ` with a `last_grant` pointer input;
  - outputs one-hot winner and any-valid.
- FSM, counters and output registers live in `uart_tx_arbiter`.

## Test plan
- After reset, req0 sends "Tartz" (last on 'z'); a transmitter model returns `tx_done` 10 clocks after each `tx_start` -> five `tx_start` pulses with `tx_data` 0x54, 0x61, 0x72, 0x74, 0x7A; `grant`=01 throughout; then 16 idle clocks before IDLE.
- req0 and req1 both valid from reset, each sending 2-byte messages repeatedly -> grants alternate 01, 10, 01, 10; no message is interleaved with another.
- req1 holds valid while req0 sends a 3-byte message -> `req_ready[1]` stays 0 until req0's last `tx_done`; req1 is granted on the first IDLE after GAP.
- req0 sends one byte without last, then drops valid, with `STALL_LIMIT`=8 -> one `abort` pulse 8 clocks after WAIT exit; `grant`=0; no further `tx_start`.
- Spurious `tx_done` in IDLE, in GAP, and coincident with `tx_start` -> no state change and no extra `req_ready`.
- Assert `rst` during WAIT of byte 3 -> next cycle all outputs at reset values; the next message restarts at its first byte from requester 0.
